key_word_xform: RTL and testbench

Parametrised AES key-schedule word transform, next generation of the single-lane g-function. It covers all three key sizes: the full RotWord/SubWord/Rcon path for AES-128/192/256, and the SubWord-only path that AES-256 needs at word index i mod 8 == 4. It has a configurable number of parallel S-box lanes and a start/done handshake. It sits inside the key expansion unit, between the key register file and the round-key XOR chain.

---
 rtl/key_word_xform_pkg.sv | 21 ++
 rtl/key_word_xform_rcon.sv | 16 +
 rtl/key_word_xform_sbytes.sv | 41 ++++
 rtl/key_word_xform.sv | 118 +++++++++++
 tb/tb_key_word_xform.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/key_word_xform_pkg.sv
// Shared key-schedule definitions: transform FSM states, mode encodings and
// the round-constant table used by the Rcon lookup.
package key_word_xform_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        FINAL,
        DONE
    } state_t;

    localparam logic ROT_SUB_RCON = 1'b0;
    localparam logic SUB_ONLY     = 1'b1;

    localparam logic [7:0] RCON_TABLE [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

endpackage

// File: rtl/key_word_xform_rcon.sv
// Round-constant lookup; indices outside 1..10 yield zero.
module rcon
    import key_word_xform_pkg::*;
(
    input  logic [3:0] round_num,
    output logic [7:0] rcon_byte
);

    always_comb begin
        rcon_byte = 8'h00;
        if (round_num >= 4'd1 && round_num <= 4'd10) begin
            rcon_byte = RCON_TABLE[round_num - 4'd1];
        end
    end

endmodule

// File: rtl/key_word_xform_sbytes.sv
// Combinational AES S-box for one byte: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module sbytes (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // a^254 is the inverse for non-zero a and maps zero to zero, as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(byte_in);
        byte_out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_word_xform.sv
// AES key-schedule word transform (RotWord/SubWord/Rcon or SubWord only) with
// SBOX_LANES bytes substituted per cycle and a start/done handshake.
module key_word_xform #(
    parameter int SBOX_LANES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] word_in,
    input  logic [3:0]  round_num,
    output logic [31:0] word_out,
    output logic        busy,
    output logic        done
);
    import key_word_xform_pkg::*;

    localparam int         N_GROUPS   = 4 / SBOX_LANES;
    localparam logic [1:0] LAST_GROUP = 2'(N_GROUPS - 1);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("key_word_xform: SBOX_LANES must be 1, 2 or 4");
    end

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  grp_cnt;
    logic [31:0] work;
    logic [31:0] work_sub;
    logic [31:0] cap_word;
    logic        cap_mode;
    logic [3:0]  cap_round;
    logic [7:0]  rcon_byte;

    logic [1:0]  lane_idx [SBOX_LANES];
    logic [7:0]  lane_in  [SBOX_LANES];
    logic [7:0]  lane_out [SBOX_LANES];

    // Lane k works on byte grp_cnt*SBOX_LANES + k, counting up from bits [7:0]
    for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
        assign lane_idx[k] = 2'(int'(grp_cnt) * SBOX_LANES + k);
        assign lane_in[k]  = work[{lane_idx[k], 3'b000} +: 8];
        sbytes u_sbytes (
            .byte_in  (lane_in[k]),
            .byte_out (lane_out[k])
        );
    end

    always_comb begin
        work_sub = work;
        for (int k = 0; k < SBOX_LANES; k++) begin
            work_sub[{lane_idx[k], 3'b000} +: 8] = lane_out[k];
        end
    end

    rcon u_rcon (
        .round_num (cap_round),
        .rcon_byte (rcon_byte)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SUB;
            SUB:     if (grp_cnt >= LAST_GROUP) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cap_word  <= '0;
            cap_mode  <= ROT_SUB_RCON;
            cap_round <= '0;
            work      <= '0;
            grp_cnt   <= '0;
            word_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_word  <= word_in;
                        cap_mode  <= mode;
                        cap_round <= round_num;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    work    <= (cap_mode == ROT_SUB_RCON) ? {cap_word[23:0], cap_word[31:24]}
                                                          : cap_word;
                    grp_cnt <= '0;
                end
                SUB: begin
                    work    <= work_sub;
                    grp_cnt <= grp_cnt + 2'd1;
                end
                FINAL: begin
                    word_out <= (cap_mode == ROT_SUB_RCON) ? (work ^ {rcon_byte, 24'h0}) : work;
                    done     <= 1'b1;
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_word_xform.sv
// Bench for key_word_xform: three instances (1, 2 and 4 S-box lanes) share the
// operand inputs, each with its own start, checked against a timed scoreboard.
module tb_key_word_xform;

    typedef struct {
        logic [31:0] w;
        int          se;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        mode;
    logic [31:0] word_in;
    logic [3:0]  round_num;
    logic        start_v [3];
    logic [31:0] wo_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];

    exp_t        exp_q [3][$];
    logic [31:0] last_word [3];
    int          last_done [3];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        key_word_xform #(.SBOX_LANES(1 << g)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .start     (start_v[g]),
            .mode      (mode),
            .word_in   (word_in),
            .round_num (round_num),
            .word_out  (wo_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: busy/done timing derived from the start edge, word_out on done
    always @(negedge clk) begin
        int rel;
        int ng;
        for (int g = 0; g < 3; g++) begin
            ng  = 4 >> g;
            rel = (exp_q[g].size() > 0) ? (cyc - exp_q[g][0].se) : -1;
            check($sformatf("busy_l%0d_c%0d", 1 << g, cyc), {31'b0, busy_v[g]},
                  {31'b0, (rel >= 0 && rel <= ng + 2)});
            check($sformatf("done_l%0d_c%0d", 1 << g, cyc), {31'b0, done_v[g]},
                  {31'b0, (rel == ng + 2)});
            if (rel == ng + 2) begin
                check($sformatf("word_l%0d_c%0d", 1 << g, cyc), wo_v[g], exp_q[g][0].w);
                last_word[g] = exp_q[g][0].w;
                last_done[g] = cyc;
                void'(exp_q[g].pop_front());
            end else begin
                check($sformatf("hold_l%0d_c%0d", 1 << g, cyc), wo_v[g], last_word[g]);
            end
        end
    end

    task automatic launch(input logic [2:0] mask, input logic m, input logic [3:0] r,
                          input logic [31:0] w, input logic [31:0] expw);
        exp_t e;
        mode      = m;
        round_num = r;
        word_in   = w;
        for (int g = 0; g < 3; g++) begin
            if (mask[g]) begin
                start_v[g] = 1'b1;
                e.w  = expw;
                e.se = cyc + 1;
                exp_q[g].push_back(e);
            end
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done(input int g, input int budget);
        for (int i = 0; i < budget && done_v[g] !== 1'b1; i++) @(negedge clk);
        check($sformatf("done_seen_l%0d", 1 << g), {31'b0, done_v[g]}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        n_rst     = 1'b0;
        mode      = 1'b0;
        word_in   = '0;
        round_num = '0;
        for (int g = 0; g < 3; g++) begin
            start_v[g]   = 1'b0;
            last_word[g] = '0;
            last_done[g] = 0;
        end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Directed vectors on all lane counts at once
        launch(3'b111, 1'b0, 4'd1,  32'h09CF4F3C, 32'h8B84EB01);
        wait_quiet(20);
        launch(3'b111, 1'b1, 4'd1,  32'h00000000, 32'h63636363);
        wait_quiet(20);
        launch(3'b111, 1'b0, 4'd10, 32'h00000000, 32'h55636363);
        wait_quiet(20);
        launch(3'b111, 1'b0, 4'd0,  32'h00000000, 32'h63636363);
        wait_quiet(20);
        launch(3'b111, 1'b1, 4'd3,  32'h09CF4F3C, 32'h018A84EB);
        wait_quiet(20);
        launch(3'b111, 1'b0, 4'd10, 32'h09CF4F3C, 32'hBC84EB01);
        wait_quiet(20);
        launch(3'b111, 1'b0, 4'd11, 32'h09CF4F3C, 32'h8A84EB01);
        wait_quiet(20);

        // Inputs change after capture, and a start arrives during SUB
        launch(3'b111, 1'b0, 4'd1, 32'h09CF4F3C, 32'h8B84EB01);
        word_in   = 32'hFFFFFFFF;
        mode      = 1'b1;
        round_num = 4'd5;
        @(negedge clk);
        for (int g = 0; g < 3; g++) start_v[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
        wait_quiet(20);
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of SUB
        launch(3'b111, 1'b0, 4'd1, 32'h09CF4F3C, 32'h8B84EB01);
        @(negedge clk);
        #3 n_rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            exp_q[g].delete();
            last_word[g] = '0;
        end
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_word_l%0d", 1 << g), wo_v[g], 32'd0);
            check($sformatf("rst_busy_l%0d", 1 << g), {31'b0, busy_v[g]}, 32'd0);
            check($sformatf("rst_done_l%0d", 1 << g), {31'b0, done_v[g]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        launch(3'b111, 1'b0, 4'd1, 32'h09CF4F3C, 32'h8B84EB01);
        wait_quiet(20);

        // Back-to-back: start held through DONE (ignored) and the first IDLE cycle (accepted)
        for (int g = 0; g < 3; g++) begin
            launch(3'(1 << g), 1'b0, 4'd1, 32'h09CF4F3C, 32'h8B84EB01);
            wait_done(g, 20);
            first      = cyc;
            start_v[g] = 1'b1;
            @(negedge clk);
            launch(3'(1 << g), 1'b0, 4'd10, 32'h00000000, 32'h55636363);
            wait_done(g, 20);
            check($sformatf("spacing_l%0d", 1 << g), cyc - first, (4 >> g) + 4);
            wait_quiet(20);
        end

        repeat (4) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("final_idle_l%0d", 1 << g), {31'b0, busy_v[g]}, 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
